// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if: bundles the fetch, debug and ROM-side signals of the
// instruction ROM port arbiter. The master modport is the requester/ROM side,
// the slave modport is the arbiter itself. owner_state exposes the arbiter's
// owner register for observation.
//
// Handshake: a requester raises its req with a stable address. The arbiter
// answers in the same cycle: fetch is told to hold by if_stall, and debug is
// told it was accepted by dbg_grant. Debug must keep dbg_req and dbg_addr
// stable until dbg_grant. The matching *_valid pulses exactly one cycle after
// the accepting cycle.
interface rom_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_stall;
  logic        if_valid;
  logic [31:0] if_data;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_grant;
  logic        dbg_valid;
  logic [31:0] dbg_data;
  logic        dbg_err;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [1:0]  owner_state;

  modport master (
    output if_req, if_addr, dbg_req, dbg_addr, rom_data,
    input  if_stall, if_valid, if_data, dbg_grant, dbg_valid, dbg_data,
           dbg_err, rom_addr, owner_state
  );

  modport slave (
    input  if_req, if_addr, dbg_req, dbg_addr, rom_data,
    output if_stall, if_valid, if_data, dbg_grant, dbg_valid, dbg_data,
           dbg_err, rom_addr, owner_state
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the single synchronous ROM read port between the
// fetch stage and a debug read requester. Fetch has priority. When the macro
// ROM_ARB_STARVE_GUARD_EN is defined, a starvation counter forces a debug slot
// after STARVE_LIMIT consecutive denied debug cycles. When the macro is not
// defined, priority is strictly fetch-first.
// The owner register records who holds the one outstanding read, so that the
// returned word (one cycle latency) can be steered to that requester.
module rom_port_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clock,
  input  logic           reset,
  rom_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_IF      = 2'd1,
    OWN_DBG     = 2'd2,
    OWN_DBG_ERR = 2'd3
  } owner_t;

  owner_t      owner_q;
  owner_t      owner_d;
  logic [31:0] last_addr_q;
  logic [31:0] rom_addr_c;
  logic        force_dbg;
  logic        fetch_win;
  logic        dbg_win;
  logic        dbg_legal;

`ifdef ROM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_q;

  assign force_dbg = (starve_q == 4'(STARVE_LIMIT));

  // Count consecutive denied debug cycles, saturating at the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= 4'd0;
    end else if (bus.dbg_req && !bus.dbg_grant) begin
      if (starve_q != 4'(STARVE_LIMIT)) starve_q <= starve_q + 4'd1;
    end else begin
      starve_q <= 4'd0;
    end
  end
`else
  assign force_dbg = 1'b0;
`endif

  // A debug address is legal when it is word aligned and inside the ROM.
  assign dbg_legal = (bus.dbg_addr[1:0] == 2'b00) &&
                     ((bus.dbg_addr >> (ADDR_WIDTH + 2)) == 32'd0);

  assign fetch_win     = bus.if_req && !(force_dbg && bus.dbg_req);
  assign dbg_win       = bus.dbg_req && !fetch_win;
  assign bus.if_stall  = bus.if_req && !fetch_win;
  assign bus.dbg_grant = dbg_win;
  assign bus.rom_addr  = rom_addr_c;

  // Choose the winner's address and the next owner. An illegal debug request
  // still takes the slot, but the ROM is not re-addressed.
  always_comb begin
    owner_d    = OWN_NONE;
    rom_addr_c = last_addr_q;
    if (fetch_win) begin
      owner_d    = OWN_IF;
      rom_addr_c = bus.if_addr;
    end else if (dbg_win) begin
      if (dbg_legal) begin
        owner_d    = OWN_DBG;
        rom_addr_c = bus.dbg_addr;
      end else begin
        owner_d    = OWN_DBG_ERR;
      end
    end
  end

  // Owner register and last issued address; reset drops any in-flight read.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q     <= OWN_NONE;
      last_addr_q <= 32'd0;
    end else begin
      owner_q <= owner_d;
      if (owner_d == OWN_IF || owner_d == OWN_DBG) last_addr_q <= rom_addr_c;
    end
  end

  assign bus.owner_state = owner_q;
  assign bus.if_valid    = (owner_q == OWN_IF);
  assign bus.if_data     = (owner_q == OWN_IF) ? bus.rom_data : 32'd0;
  assign bus.dbg_valid   = (owner_q == OWN_DBG) || (owner_q == OWN_DBG_ERR);
  assign bus.dbg_err     = (owner_q == OWN_DBG_ERR);
  assign bus.dbg_data    = (owner_q == OWN_DBG) ? bus.rom_data : 32'd0;

endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Shares the single synchronous read port of the instruction ROM between the fetch stage and a debug/data read requester. Fetch normally has priority. A starvation guard optionally forces a debug slot and stalls fetch for one cycle. The block sits between the PC/fetch logic, the debug read port, and the ROM. It tracks which requester owns the one outstanding read and routes the returned word to that requester.

## Interface
- ADDR_WIDTH, 8, log2 of ROM depth in 32-bit words; must match the ROM instance
- STARVE_LIMIT, 4, consecutive denied debug cycles before a debug slot is forced (1..15)

- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- if_req  in  1  fetch requests a read this cycle
- if_addr  in  32  fetch byte address
- if_stall  out  1  fetch request was denied this cycle; PC must hold
- if_valid  out  1  if_data holds the word for the fetch issued last cycle
- if_data  out  32  fetch read data
- dbg_req  in  1  debug read request; held with dbg_addr until dbg_grant
- dbg_addr  in  32  debug byte address
- dbg_grant  out  1  debug request accepted this cycle
- dbg_valid  out  1  dbg_data/dbg_err valid for the debug request granted last cycle
- dbg_data  out  32  debug read data; 0 when dbg_err
- dbg_err  out  1  debug address was misaligned or out of range
- rom_addr  out  32  address presented to ROM addr_in
- rom_data  in  32  ROM data_out; already byte-ordered, one-cycle latency

## Operation
- Arbitration is combinational within cycle N:
  - If the force condition is set and dbg_req is high, debug wins.
  - Otherwise, if if_req is high, fetch wins.
  - Otherwise, if dbg_req is high, debug wins.
  - Otherwise, no grant.
- if_stall = if_req && !fetch_win.
- dbg_grant = dbg_req && !fetch_win.
- rom_addr = address of the winner. With no winner, rom_addr holds the last issued address from a register (reset 0).
- Debug address check:
  - Legal when dbg_addr[1:0]==0 and dbg_addr[31:ADDR_WIDTH+2]==0.
  - An illegal request is still granted and sets owner DBG_ERR. rom_addr holds (ROM is not re-addressed).
- Owner register owner_q takes one of NONE, IF, DBG, DBG_ERR. It is loaded every cycle from the winner; NONE when there is no grant.
- Responses in cycle N+1, decoded from owner_q:
  - IF: if_valid=1, if_data=rom_data.
  - DBG: dbg_valid=1, dbg_data=rom_data, dbg_err=0.
  - DBG_ERR: dbg_valid=1, dbg_data=0, dbg_err=1.
  - Non-owner data outputs read 0.
- Fetch addresses are not checked. The ROM index uses addr[ADDR_WIDTH+1:2]; upper bits are ignored by the ROM.
- Back-to-back grants are allowed every cycle; there is no bubble between requesters.

## Timing
- Read latency is exactly 1 cycle: grant in N, valid in N+1.
- Reset, applied at edge E:
  - owner_q=NONE, starve counter=0, last-address register=0.
  - In the cycle after E: if_valid=dbg_valid=dbg_err=0, if_data=dbg_data=0.
- Grant and stall outputs are combinational from requests, so they follow their inputs even during reset.
- Reset asserted mid-operation: a read granted in the cycle when reset is sampled produces no valid. The ROM also returns 0 under reset.
- Simultaneous if_req and dbg_req without the force condition: fetch granted, if_stall=0, dbg_grant=0, dbg_req must stay high.
- Deasserting dbg_req before grant is a requester protocol violation; the arbiter simply drops the request.
- Starve counter, 4 bits, saturating at STARVE_LIMIT:
  - Increments each cycle dbg_req && !dbg_grant.
  - Clears on dbg_grant or on !dbg_req.
  - Force condition: counter == STARVE_LIMIT.

## Configuration
- ROM_ARB_STARVE_GUARD_EN:
  - Defined: the starve counter and force condition are built as above. Debug waits at most STARVE_LIMIT cycles under continuous fetch.
  - Undefined: no counter is instantiated and the force condition is constant 0. Priority is strict fetch-first, so debug is granted only in cycles with if_req=0.

## Test plan
- Reset, then if_req=1, if_addr=0x00000008 for one cycle:
  - rom_addr=0x8 in that cycle.
  - Next cycle if_valid=1, if_data=ROM word 2. dbg_valid=0.
- Continuous if_req with dbg_req=1, dbg_addr=0x10, STARVE_LIMIT=4, guard enabled:
  - dbg_grant=0 for 4 cycles.
  - 5th cycle dbg_grant=1, if_stall=1.
  - Next cycle dbg_valid=1, dbg_data=ROM word 4.
  - Counter is 0 afterwards.
- Same stimulus with guard disabled: dbg_grant stays 0 until if_req drops. It is granted in the first cycle with if_req=0.
- if_req=0, dbg_req=1, dbg_addr=0x6 (misaligned):
  - dbg_grant=1 immediately.
  - Next cycle dbg_valid=1, dbg_err=1, dbg_data=0.
  - rom_addr is unchanged.
- Same with dbg_addr=0x400 and ADDR_WIDTH=8 (out of range): same response, dbg_err=1.
- Fetch granted in cycle N with reset asserted in N: no if_valid in N+1, all outputs are at reset values in N+1, owner_q=NONE.
